// File: rtl/io_pad_arbiter_if.sv
// Request/grant bundle between the peripheral cores and the pad arbiter.
// The master modport belongs to the requesting side; the arbiter takes the slave view.
interface io_pad_arbiter_if #(
  parameter int NFUNC    = 4,
  parameter int MUXWIDTH = $clog2(NFUNC)
);
  logic [NFUNC-1:0]    req;
  logic [NFUNC-1:0]    grant;
  logic [MUXWIDTH-1:0] func_select;
  logic                busy;
  logic                preempted;

  modport master (output req, input grant, input func_select, input busy, input preempted);
  modport slave  (input req, output grant, output func_select, output busy, output preempted);
endinterface

// File: rtl/io_pad_arbiter.sv
// Round-robin owner sequencing for one shared IO pad, with an optional hold limit
// and a tri-state turnaround after every transmit owner.
module io_pad_arbiter #(
  parameter int TXCOUNT    = 2,
  parameter int RXCOUNT    = 2,
  parameter int TURNAROUND = 2,
  parameter int MAX_HOLD   = 0
) (
  input  logic            clk,
  input  logic            rst,
  io_pad_arbiter_if.slave bus_if
);
  localparam int NFUNC    = TXCOUNT + RXCOUNT;
  localparam int MUXWIDTH = $clog2(NFUNC);
  localparam int MW1      = MUXWIDTH + 1;
  localparam int HOLDW    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [HOLDW-1:0]    HOLD_MAX  = HOLDW'(MAX_HOLD);
  localparam logic [HOLDW-1:0]    HOLD_LAST = (MAX_HOLD > 0) ? HOLDW'(MAX_HOLD - 1) : '0;
  localparam logic [3:0]          TURN_LAST = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;
  localparam logic [MUXWIDTH-1:0] FIRST_TX  = MUXWIDTH'(RXCOUNT);
  localparam logic [MW1-1:0]      NFUNC_W   = MW1'(NFUNC);

  if (TXCOUNT <= 0 || RXCOUNT <= 0) begin : g_bad_count
    $error("io_pad_arbiter: TXCOUNT and RXCOUNT must both be > 0");
  end
  if (TURNAROUND < 0 || TURNAROUND > 15 || MAX_HOLD < 0) begin : g_bad_timing
    $error("io_pad_arbiter: TURNAROUND must be 0..15 and MAX_HOLD >= 0");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_TURN} state_t;

  state_t              state_q, state_d;
  logic [MUXWIDTH-1:0] rr_q, rr_d;
  logic [MUXWIDTH-1:0] sel_q, sel_d;
  logic [MUXWIDTH-1:0] owner_d;
  logic [NFUNC-1:0]    grant_q, grant_d;
  logic [HOLDW-1:0]    hold_q, hold_d;
  logic [3:0]          turn_q, turn_d;
  logic                busy_q, busy_d;
  logic                pre_q, pre_d;
  logic                preempt;

  logic [NFUNC-1:0]    req_rot;
  logic [MUXWIDTH-1:0] win_off;
  logic [MUXWIDTH-1:0] win_code;
  logic                owner_req;
  logic                others_req;
  logic                limit_hit;

  function automatic logic [MUXWIDTH-1:0] wrap_add(input logic [MUXWIDTH-1:0] a,
                                                   input logic [MUXWIDTH-1:0] b);
    logic [MW1-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= NFUNC_W) s = s - NFUNC_W;
    return s[MUXWIDTH-1:0];
  endfunction

  // req_rot[k] is the request k positions after the round-robin pointer.
  for (genvar gi = 0; gi < NFUNC; gi++) begin : g_rot
    logic [MUXWIDTH-1:0] idx;
    assign idx         = wrap_add(rr_q, MUXWIDTH'(gi));
    assign req_rot[gi] = bus_if.req[idx];
  end

  always_comb begin
    win_off = '0;
    for (int k = NFUNC - 1; k >= 0; k--) begin
      if (req_rot[k]) win_off = MUXWIDTH'(k);
    end
  end

  assign win_code   = wrap_add(rr_q, win_off);
  assign owner_req  = bus_if.req[sel_q];
  assign others_req = |(bus_if.req & ~grant_q);
  assign limit_hit  = (MAX_HOLD > 0) && (hold_q >= HOLD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
      grant_q <= '0;
      hold_q  <= '0;
      turn_q  <= '0;
      busy_q  <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      turn_q  <= turn_d;
      busy_q  <= busy_d;
      pre_q   <= pre_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = sel_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    turn_d  = turn_q;
    preempt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|bus_if.req) begin
          state_d = ST_GRANT;
          owner_d = win_code;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        // An owner that drops its request in the limit cycle is a plain release.
        if (!owner_req || (limit_hit && others_req)) begin
          preempt = owner_req;
          rr_d    = wrap_add(sel_q, MUXWIDTH'(1));
          owner_d = '0;
          turn_d  = '0;
          state_d = (TURNAROUND > 0 && sel_q >= FIRST_TX) ? ST_TURN : ST_IDLE;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + HOLDW'(1);
        end
      end
      ST_TURN: begin
        if (turn_q == TURN_LAST) state_d = ST_IDLE;
        else                     turn_d  = turn_q + 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_d != ST_IDLE);
    sel_d  = (state_d == ST_GRANT) ? owner_d : '0;
    pre_d  = preempt;
  end

  for (genvar gi = 0; gi < NFUNC; gi++) begin : g_grant
    assign grant_d[gi] = (state_d == ST_GRANT) && (owner_d == MUXWIDTH'(gi));
  end

  assign bus_if.grant       = grant_q;
  assign bus_if.func_select = sel_q;
  assign bus_if.busy        = busy_q;
  assign bus_if.preempted   = pre_q;
endmodule

// File: tb/tb_io_pad_arbiter.sv
// Directed scoreboard bench for io_pad_arbiter: two instances (hold limit 5 and 4),
// per-cycle expected outputs queued by the stimulus and popped by a monitor.
module tb_io_pad_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  io_pad_arbiter_if #(.NFUNC(4)) ifa ();
  io_pad_arbiter_if #(.NFUNC(4)) ifb ();

  io_pad_arbiter #(.TXCOUNT(2), .RXCOUNT(2), .TURNAROUND(2), .MAX_HOLD(5)) u_dut_a (
    .clk(clk), .rst(rst), .bus_if(ifa)
  );
  io_pad_arbiter #(.TXCOUNT(2), .RXCOUNT(2), .TURNAROUND(2), .MAX_HOLD(4)) u_dut_b (
    .clk(clk), .rst(rst), .bus_if(ifb)
  );

  typedef struct {
    int         dut;
    logic [3:0] req;
    logic [7:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Observed outputs packed as {grant[3:0], func_select[1:0], busy, preempted}.
  function automatic logic [7:0] obs(input int d);
    if (d == 0) return {ifa.grant, ifa.func_select, ifa.busy, ifa.preempted};
    return {ifb.grant, ifb.func_select, ifb.busy, ifb.preempted};
  endfunction

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got grant=%b sel=%0d busy=%b pre=%b, want grant=%b sel=%0d busy=%b pre=%b",
                  tag, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
  endtask

  // Drive req for the next edge and queue the outputs expected right after it.
  task automatic step(input int d, input logic [3:0] r, input logic [3:0] g,
                      input logic [1:0] s, input logic b, input logic p, input string tag);
    exp_t e;
    @(posedge clk);
    #2;
    if (d == 0) begin ifa.req = r; ifb.req = '0; end
    else        begin ifb.req = r; ifa.req = '0; end
    e.dut = d; e.req = r; e.exp = {g, s, b, p}; e.tag = tag;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = obs(e.dut);
        $display("tx dut%0d %-14s req=%b grant=%b sel=%0d busy=%b pre=%b",
                 e.dut, e.tag, e.req, act[7:4], act[3:2], act[1], act[0]);
        check(e.tag, act, e.exp);
      end
    end
  end

  task automatic inv(input int d);
    logic [7:0] o;
    logic [3:0] dec;
    o   = obs(d);
    dec = 4'b0001 << o[3:2];
    check($sformatf("onehot_dut%0d", d), {o[7:2], 2'b00},
          {(o[7:4] == 4'b0000) ? 4'b0000 : dec, o[3:2], 2'b00});
  endtask

  initial begin : invariant
    forever begin
      @(negedge clk);
      if (!rst) begin
        inv(0);
        inv(1);
      end
    end
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: run exceeded 50000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] gv;
    logic       tx;
    rst     = 1'b1;
    ifa.req = '0;
    ifb.req = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_a", obs(0), 8'h00);
    check("reset_b", obs(1), 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Round robin with all four requesting; each owner keeps the pad 3 cycles.
    for (int k = 0; k < 4; k++) begin
      gv = 4'b0001 << k;
      tx = (k >= 2);
      repeat (3) step(0, 4'b1111, gv, 2'(k), 1'b1, 1'b0, $sformatf("rr_hold%0d", k));
      step(0, 4'b1111 & ~gv, 4'b0000, 2'd0, tx, 1'b0, $sformatf("rr_rel%0d", k));
      if (tx) begin
        step(0, 4'b1111, 4'b0000, 2'd0, 1'b1, 1'b0, "rr_turn2");
        step(0, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_idle");
      end
    end
    step(0, 4'b1111, 4'b0001, 2'd0, 1'b1, 1'b0, "rr_wrap0");
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rr_done");

    // Transmit owner 2, then exactly two turnaround cycles.
    step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "basic_grant");
    step(0, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "basic_hold");
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, "basic_turn1");
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, "basic_turn2");
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "basic_idle");

    // Receive owner 0 releases with 1 pending: one idle cycle only.
    step(0, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, "rx_grant0");
    step(0, 4'b0011, 4'b0001, 2'd0, 1'b1, 1'b0, "rx_hold0");
    step(0, 4'b0010, 4'b0000, 2'd0, 1'b0, 1'b0, "rx_gap");
    step(0, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "rx_grant1");
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "rx_done");

    // Hold limit 5: owner 3 revoked with a competitor pending from cycle 1.
    step(0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, "pre_grant3");
    repeat (4) step(0, 4'b1001, 4'b1000, 2'd3, 1'b1, 1'b0, "pre_hold3");
    step(0, 4'b1001, 4'b0000, 2'd0, 1'b1, 1'b1, "pre_revoke");
    step(0, 4'b1001, 4'b0000, 2'd0, 1'b1, 1'b0, "pre_turn2");
    step(0, 4'b1001, 4'b0000, 2'd0, 1'b0, 1'b0, "pre_idle");
    step(0, 4'b1001, 4'b0001, 2'd0, 1'b1, 1'b0, "pre_grant0");
    step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "pre_done");

    // Hold limit 4: owner drops in the limit cycle, so no preempted pulse.
    step(1, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0, "sim_grant1");
    repeat (3) step(1, 4'b0011, 4'b0010, 2'd1, 1'b1, 1'b0, "sim_hold1");
    step(1, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0, "sim_release");
    step(1, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b0, "sim_grant0");
    step(1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "sim_done");

    // Lone requester outlasting the hold limit is never revoked.
    repeat (7) step(1, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b0, "solo_hold2");
    step(1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, "solo_turn1");
    step(1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, "solo_turn2");
    step(1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "solo_idle");

    // Asynchronous reset while owner 3 drives the pad.
    step(0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, "ar_grant3");
    step(0, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b0, "ar_hold3");
    @(posedge clk);
    #3;
    rst     = 1'b1;
    ifa.req = '0;
    #1;
    check("async_rst_a", obs(0), 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "parked");

    @(posedge clk);
    #4;
    check("sb_drain", 8'(sb.size()), 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
